// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and constants for the unified memory arbiter.
package riscv_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned ILEN   = 32;
    localparam int unsigned WAIT_W = 4;
    localparam int unsigned OWN_W  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    localparam logic [OWN_W-1:0] OWN_NONE = 2'b00;
    localparam logic [OWN_W-1:0] OWN_IF   = 2'b01;
    localparam logic [OWN_W-1:0] OWN_D    = 2'b10;

    // Memory-side command captured at grant time
    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } mem_cmd_t;

    // Doubleword-align a byte address
    function automatic logic [XLEN-1:0] dw_align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:3], 3'b000};
    endfunction

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Requester and memory-side signals of the unified memory arbiter.
interface unified_mem_arbiter_if;
    import riscv_pkg::*;

    logic                 if_req;
    logic [XLEN-1:0]      if_addr;
    logic                 if_ready;
    logic [ILEN-1:0]      if_rdata;
    logic                 d_req;
    logic                 d_we;
    logic [XLEN-1:0]      d_addr;
    logic [XLEN-1:0]      d_wdata;
    logic                 d_ready;
    logic [XLEN-1:0]      d_rdata;
    logic                 mem_req;
    logic                 mem_we;
    logic [XLEN-1:0]      mem_addr;
    logic [XLEN-1:0]      mem_wdata;
    logic                 mem_ack;
    logic [XLEN-1:0]      mem_rdata;
    logic                 stall_if;
    logic                 stall_mem;
    logic [OWN_W-1:0]     owner;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        output if_ready, if_rdata, d_ready, d_rdata, mem_req, mem_we, mem_addr,
               mem_wdata, stall_if, stall_mem, owner
    );

    // Pipeline stages plus memory side
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        input  if_ready, if_rdata, d_ready, d_rdata, mem_req, mem_we, mem_addr,
               mem_wdata, stall_if, stall_mem, owner
    );

endinterface

// File: rtl/unified_mem_arbiter_wait_counter.sv
// Saturating counter with clear priority over increment.
module arb_wait_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    input  logic         clr_i,
    input  logic [W-1:0] sat_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Count register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    // Clear wins; increment stops at the saturation level
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)                      cnt_d = '0;
        else if (inc_i && cnt_q < sat_i) cnt_d = cnt_q + W'(1);
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access.
module unified_mem_arbiter
    import riscv_pkg::*;
#(
    parameter int unsigned IF_MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    unified_mem_arbiter_if.slave  bus
);

    arb_state_t        state_q, state_d;
    mem_cmd_t          cmd_q, cmd_d;
    logic              if_grant, d_grant;
    logic              if_starved;
    logic [WAIT_W-1:0] if_wait;

    assign if_starved = (if_wait == WAIT_W'(IF_MAX_WAIT));

    // State and captured memory command
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
        end
    end

    // Grant decision in IDLE, ack-driven return to IDLE from BUSY
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        if_grant = 1'b0;
        d_grant  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.d_req && !(bus.if_req && if_starved)) begin
                    d_grant = 1'b1;
                    state_d = BUSY_D;
                    cmd_d   = '{we: bus.d_we, addr: dw_align(bus.d_addr), wdata: bus.d_wdata};
                end else if (bus.if_req) begin
                    if_grant = 1'b1;
                    state_d  = BUSY_I;
                    cmd_d    = '{we: 1'b0, addr: dw_align(bus.if_addr), wdata: '0};
                end
            end
            BUSY_I, BUSY_D: begin
                if (bus.mem_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // IF starvation tracking: data grants that bypassed a waiting fetch
    arb_wait_counter #(.W(WAIT_W)) u_wait (
        .clk   (clk),
        .reset (reset),
        .inc_i (d_grant && bus.if_req),
        .clr_i (if_grant),
        .sat_i (WAIT_W'(IF_MAX_WAIT)),
        .cnt_o (if_wait)
    );

    assign bus.mem_req   = (state_q != IDLE);
    assign bus.mem_we    = cmd_q.we;
    assign bus.mem_addr  = cmd_q.addr;
    assign bus.mem_wdata = cmd_q.wdata;
    assign bus.owner     = (state_q == BUSY_I) ? OWN_IF :
                           (state_q == BUSY_D) ? OWN_D  : OWN_NONE;

    assign bus.if_ready  = (state_q == BUSY_I) && bus.mem_ack;
    assign bus.d_ready   = (state_q == BUSY_D) && bus.mem_ack;
    assign bus.if_rdata  = bus.if_addr[2] ? bus.mem_rdata[XLEN-1:ILEN] : bus.mem_rdata[ILEN-1:0];
    assign bus.d_rdata   = bus.mem_rdata;
    assign bus.stall_if  = bus.if_req && !bus.if_ready;
    assign bus.stall_mem = bus.d_req && !bus.d_ready;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: directed requests, memory responder, ready monitor.
module tb_unified_mem_arbiter;

    logic clk;
    logic reset;

    unified_mem_arbiter_if bus ();

    unified_mem_arbiter #(.IF_MAX_WAIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_d;
        logic [63:0] data;
        logic [63:0] maddr;
        bit          chk_data;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   rdy_cnt = 0;
    int   ack_delay = 1;
    bit   mem_en = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic push(input bit is_d, input logic [63:0] data, input logic [63:0] maddr, input bit cd);
        exp_t e;
        e.is_d = is_d; e.data = data; e.maddr = maddr; e.chk_data = cd;
        sb.push_back(e);
    endtask

    function automatic logic [63:0] mdl(input logic [63:0] a);
        return {32'h1111_0000 + a[31:0], 32'h2222_0000 + a[31:0]};
    endfunction

    // Memory responder: ack after ack_delay cycles of mem_req
    initial begin
        int cnt;
        cnt = 0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (!mem_en) cnt = 0;
            else if (bus.mem_ack) begin bus.mem_ack = 1'b0; cnt = 0; end
            else if (bus.mem_req) begin
                cnt++;
                if (cnt >= ack_delay) begin
                    bus.mem_ack = 1'b1;
                    bus.mem_rdata = mdl(bus.mem_addr);
                end
            end else cnt = 0;
        end
    end

    // Monitor: every ready pops and checks one expected response
    always @(negedge clk) begin
        if (!reset && (bus.if_ready || bus.d_ready)) begin
            rdy_cnt++;
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_ready: if_ready=%0b d_ready=%0b, required none (t=%0t)",
                         bus.if_ready, bus.d_ready, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_kind_d_ready", 64'(bus.d_ready), 64'(e.is_d));
                chk("sb_mem_addr", bus.mem_addr, e.maddr);
                if (e.chk_data) chk("sb_rdata", e.is_d ? bus.d_rdata : 64'(bus.if_rdata), e.data);
            end
        end
    end

    // Fetch requester; caller is aligned to just after a rising edge
    task automatic if_fetch(input logic [63:0] addr, input int limit, output int n);
        n = 0;
        bus.if_req = 1'b1;
        bus.if_addr = addr;
        forever begin
            @(negedge clk); n++;
            if (bus.owner == 2'b01) begin
                chk("if_mem_we", 64'(bus.mem_we), 64'd0);
                chk("if_mem_addr", bus.mem_addr, {addr[63:3], 3'b000});
                chk("if_mem_wdata", bus.mem_wdata, 64'd0);
            end
            if (bus.if_ready) begin chk("stall_if_at_ready", 64'(bus.stall_if), 64'd0); break; end
            chk("stall_if_waiting", 64'(bus.stall_if), 64'd1);
            if (n >= limit) begin
                n_total++;
                $display("FAIL if_timeout: no if_ready after %0d cycles, required one", n);
                break;
            end
        end
        @(posedge clk); #1;
        bus.if_req = 1'b0;
    endtask

    // Data requester; caller is aligned to just after a rising edge
    task automatic d_access(input logic we, input logic [63:0] addr, input logic [63:0] wd,
                            input int limit, output int n);
        n = 0;
        bus.d_req = 1'b1;
        bus.d_we = we;
        bus.d_addr = addr;
        bus.d_wdata = wd;
        forever begin
            @(negedge clk); n++;
            if (bus.owner == 2'b10) begin
                chk("d_mem_we", 64'(bus.mem_we), 64'(we));
                chk("d_mem_addr", bus.mem_addr, {addr[63:3], 3'b000});
                chk("d_mem_wdata", bus.mem_wdata, wd);
            end
            if (bus.d_ready) begin chk("stall_mem_at_ready", 64'(bus.stall_mem), 64'd0); break; end
            chk("stall_mem_waiting", 64'(bus.stall_mem), 64'd1);
            if (n >= limit) begin
                n_total++;
                $display("FAIL d_timeout: no d_ready after %0d cycles, required one", n);
                break;
            end
        end
        @(posedge clk); #1;
        bus.d_req = 1'b0;
        bus.d_we = 1'b0;
    endtask

    initial begin
        int n;
        int rb;
        reset = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
        chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
        chk("rst_mem_addr", bus.mem_addr, 64'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 64'd0);
        chk("rst_owner", 64'(bus.owner), 64'd0);
        chk("rst_if_ready", 64'(bus.if_ready), 64'd0);
        chk("rst_d_ready", 64'(bus.d_ready), 64'd0);
        chk("rst_if_wait", 64'(dut.if_wait), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // IF only, upper word, ack two cycles after mem_req
        ack_delay = 3;
        push(1'b0, 64'h0000_0000_1111_0100, 64'h100, 1'b1);
        if_fetch(64'h104, 30, n);
        chk("if_latency_cycles", 64'(n), 64'd4);
        @(negedge clk);
        chk("if_ready_one_cycle", 64'(bus.if_ready), 64'd0);
        chk("idle_after_if", 64'(bus.owner), 64'd0);
        @(posedge clk); #1;

        // Simultaneous requests: data first, then IF (lower word)
        ack_delay = 2;
        push(1'b1, 64'h1111_2000_2222_2000, 64'h2000, 1'b1);
        push(1'b0, 64'h0000_0000_2222_0200, 64'h200, 1'b1);
        fork
            begin int nd; d_access(1'b0, 64'h2000, 64'h0, 40, nd); end
            begin int ni; if_fetch(64'h200, 40, ni); end
        join
        chk("if_wait_after_tie", 64'(dut.if_wait), 64'd0);
        @(posedge clk); #1;

        // Starvation: four data grants, then IF, then data again
        ack_delay = 1;
        for (int i = 0; i < 4; i++) push(1'b1, 64'h1111_4010_2222_4010, 64'h4010, 1'b1);
        push(1'b0, 64'h0000_0000_1111_0308, 64'h308, 1'b1);
        push(1'b1, 64'h1111_4010_2222_4010, 64'h4010, 1'b1);
        fork
            begin
                int nd;
                for (int i = 0; i < 5; i++) d_access(1'b0, 64'h4010, 64'h0, 40, nd);
            end
            begin int ni; if_fetch(64'h30C, 100, ni); end
        join
        chk("if_wait_cleared", 64'(dut.if_wait), 64'd0);
        @(posedge clk); #1;

        // Store with stable write data until ack
        ack_delay = 4;
        push(1'b1, 64'h0, 64'h3008, 1'b0);
        d_access(1'b1, 64'h3008, 64'hDEAD_BEEF_CAFE_F00D, 30, n);
        chk("store_latency_cycles", 64'(n), 64'd5);
        @(posedge clk); #1;

        // Stray ack in IDLE
        mem_en = 1'b0;
        rb = rdy_cnt;
        bus.mem_ack = 1'b1;
        @(negedge clk);
        chk("stray_if_ready", 64'(bus.if_ready), 64'd0);
        chk("stray_d_ready", 64'(bus.d_ready), 64'd0);
        chk("stray_mem_req", 64'(bus.mem_req), 64'd0);
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        chk("stray_owner_idle", 64'(bus.owner), 64'd0);
        chk("stray_no_ready", 64'(rdy_cnt - rb), 64'd0);
        @(posedge clk); #1;
        mem_en = 1'b1;

        // Reset during BUSY_D abandons the access
        ack_delay = 20;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 64'h5008; bus.d_wdata = 64'h1234_5678_9ABC_DEF0;
        repeat (2) @(posedge clk);
        #2;
        chk("pre_reset_owner", 64'(bus.owner), 64'd2);
        reset = 1'b1;
        #1;
        chk("midrst_mem_req", 64'(bus.mem_req), 64'd0);
        chk("midrst_mem_we", 64'(bus.mem_we), 64'd0);
        chk("midrst_mem_addr", bus.mem_addr, 64'd0);
        chk("midrst_mem_wdata", bus.mem_wdata, 64'd0);
        chk("midrst_owner", 64'(bus.owner), 64'd0);
        chk("midrst_d_ready", 64'(bus.d_ready), 64'd0);
        rb = rdy_cnt;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        repeat (25) @(posedge clk);
        @(negedge clk);
        chk("no_ready_after_reset", 64'(rdy_cnt - rb), 64'd0);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Arbiter and sequencer that shares one single-ported 64-bit unified memory between the instruction-fetch (IF) and data-access (MEM) stages of the 5-stage RISC-V pipeline. It grants the port to one requester at a time, holds the request stable on the memory side until the memory acknowledges, and returns data to the winner. It also produces the per-stage stall signals consumed by the IF/ID and EX/MEM pipeline registers.

## Interface
- IF_MAX_WAIT, 4: consecutive data grants while IF is waiting before IF is forced to win; legal range 1–15.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- if_req  in  1  IF stage requests a fetch; held until `if_ready`.
- if_addr  in  64  fetch byte address (PC).
- if_ready  out  1  fetch complete this cycle.
- if_rdata  out  32  instruction; valid only when `if_ready` is high.
- d_req  in  1  MEM stage requests an access; held until `d_ready`.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  64  data byte address.
- d_wdata  in  64  store data.
- d_ready  out  1  data access complete this cycle.
- d_rdata  out  64  load data; valid only when `d_ready` is high.
- mem_req  out  1  memory access pending.
- mem_we  out  1  write enable to memory.
- mem_addr  out  64  doubleword-aligned address to memory.
- mem_wdata  out  64  write data to memory.
- mem_ack  in  1  memory access done; for reads, `mem_rdata` is valid.
- mem_rdata  in  64  read data.
- stall_if  out  1  `if_req && !if_ready`.
- stall_mem  out  1  `d_req && !d_ready`.
- owner  out  2  00 = idle, 01 = IF, 10 = data.

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D. Reset puts the FSM in IDLE.
- Grant decision in IDLE:
  - Only one request high: grant it.
  - Both high: data wins, unless `if_wait == IF_MAX_WAIT`, in which case IF wins.
  - Neither high: stay in IDLE.
- On a grant, register the memory-side fields:
  - IF grant: `mem_addr = {if_addr[63:3],3'b000}`, `mem_we = 0`, `mem_wdata = 0`.
  - Data grant: `mem_addr = {d_addr[63:3],3'b000}`, `mem_we = d_we`, `mem_wdata = d_wdata`.
  - These fields stay stable for the whole BUSY state.
- In a BUSY state, `mem_req` stays high until `mem_ack` arrives. In the ack cycle:
  - The matching `*_ready` pulses for one cycle.
  - The next state is IDLE.
- Read data paths (combinational):
  - `if_rdata = if_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0]`.
  - `d_rdata = mem_rdata`; it is also driven for stores, but its value is don't-care.
- Starvation counter `if_wait` (4-bit):
  - Increments, saturating at IF_MAX_WAIT, on each data grant made while `if_req` is high.
  - Clears on every IF grant.
  - Holds otherwise.
- `mem_ack` outside BUSY is ignored; no ready pulse is generated.
- `stall_if` and `stall_mem` are combinational from the requests and readies.
- Request address and data must not change while the request is pending. The arbiter samples them only at grant time.

## Timing
- Reset values: state IDLE, `mem_req` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `owner` 00, `if_wait` 0, `if_ready` 0, `d_ready` 0.
- Request high in IDLE at cycle t → BUSY and `mem_req` high at cycle t+1.
- `mem_ack` is legal from cycle t+1 onward. With ack at cycle t+k, the requester's ready is high at t+k and the FSM is in IDLE at t+k+1.
- Minimum turnaround is 2 cycles per access. IDLE always lasts at least one cycle, even between back-to-back requests.
- A requester may deassert its request, or present a new one, in the cycle after its ready.
- When one requester is in BUSY and the other requests, the other waits with its stall high. It is arbitrated in the next IDLE cycle.
- Reset asserted mid-access: the outstanding access is abandoned immediately and no ready is produced. The memory model must tolerate the dropped `mem_req`.

## Structure
- Shared package `riscv_pkg`:
  - `arb_state_t` enum: IDLE, BUSY_I, BUSY_D.
  - Owner encodings: OWN_NONE, OWN_IF, OWN_D.
  - `XLEN = 64`, `ILEN = 32`.
- One sub-module, `arb_wait_counter`: a saturating counter with inc/clr/sat-level inputs, instantiated for `if_wait`.

## Test plan
- Reset, then IF only: `if_addr=0x104`, ack 2 cycles after `mem_req` → `mem_addr=0x100`, `if_rdata=mem_rdata[63:32]`, `if_ready` for 1 cycle, `stall_if` high until then.
- Simultaneous `if_req` and `d_req` (load at `0x2000`) → data granted first (`owner=10`). After `d_ready`, the next IDLE grants IF.
- Continuous `d_req` with `if_req` held, IF_MAX_WAIT=4 → exactly 4 data grants, then an IF grant, and `if_wait` returns to 0.
- Store, `d_we=1`, `d_wdata=0xDEADBEEF_CAFEF00D` → `mem_we=1`, and `mem_wdata` is stable on every cycle until ack.
- Stray `mem_ack` in IDLE → no ready pulse, state unchanged.
- Reset asserted while in BUSY_D → all outputs at reset values the same cycle, and no `d_ready` ever issued for that access.
